// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : RV32I fetch stage. Owns the PC, issues word reads to
//                instruction memory under a credit limit, buffers returned
//                words with their PC in an in-order FIFO and presents them to
//                decode via valid/ready. Redirects restart fetch and discard
//                wrong-path words still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0]    c_st_boot  = 2'd0;
    localparam logic [1:0]    c_st_fetch = 2'd1;
    localparam logic [1:0]    c_st_flush = 2'd2;
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [CW-1:0] c_full     = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   c_credit   = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] c_last_ptr = PW'(FIFO_DEPTH - 1);

    // Registered state and its next-state values
    logic [1:0]    state_q,     state_d;
    logic [31:0]   pc_q,        pc_d;
    logic          req_valid_q, req_valid_d;
    logic [31:0]   req_addr_q,  req_addr_d;
    logic          req_wrong_q, req_wrong_d;
    logic [CW-1:0] out_q,       out_d;
    logic [CW-1:0] drop_q,      drop_d;
    logic [31:0]   rsp_pc_q,    rsp_pc_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic [31:0]   last_data_q;
    logic [31:0]   last_pc_q;
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];

    logic          w_accept;
    logic          w_req_hold;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_credit_used;
    logic [31:0]   w_redirect_pc;
    logic          w_unused_pc_lsb;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // The two low bits of a redirect target carry no meaning for word fetch
    assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    assign w_accept   = req_valid_q && imem_req_ready;
    assign w_req_hold = req_valid_q && !imem_req_ready;
    // A response is kept only when no wrong-path words are owed and no
    // redirect is flushing the buffer this cycle
    assign w_push     = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign w_pop      = instr_valid && instr_ready && !redirect_valid;

    // Reads in flight after this cycle's accept and response
    always_comb begin
        out_d = out_q;
        if (w_accept && !imem_rsp_valid) begin
            out_d = out_q + c_one;
        end else if (!w_accept && imem_rsp_valid) begin
            out_d = out_q - c_one;
        end
    end

    // Wrong-path bookkeeping: a redirect writes off everything in flight,
    // otherwise discarded responses pay the debt down and late-accepted
    // wrong-path requests add to it
    always_comb begin
        drop_d = drop_q;
        if (redirect_valid) begin
            drop_d = out_d;
        end else begin
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_d - c_one;
            end
            if (w_accept && req_wrong_q) begin
                drop_d = drop_d + c_one;
            end
        end
    end

    // PC of the next request and PC to tag on the next kept response
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        if (redirect_valid) begin
            pc_d     = w_redirect_pc;
            rsp_pc_d = w_redirect_pc;
        end else begin
            if (w_accept && !req_wrong_q) begin
                pc_d = pc_q + 32'd4;
            end
            if (w_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
        end
    end

    // Fetch control state machine
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_boot: begin
                state_d = c_st_fetch;
            end
            c_st_fetch: begin
                if (redirect_valid && (out_d != '0)) begin
                    state_d = c_st_flush;
                end
            end
            c_st_flush: begin
                if (!redirect_valid && (drop_d == '0) && !w_req_hold) begin
                    state_d = c_st_fetch;
                end
            end
            default: begin
                state_d = c_st_boot;
            end
        endcase
    end

    // FIFO pointer and occupancy update; a redirect empties the buffer
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + c_one;
            end else if (!w_push && w_pop) begin
                count_d = count_q - c_one;
            end
        end
    end

    assign w_credit_used = {1'b0, out_d} + {1'b0, count_d};

    // Request channel: a raised request is held until accepted; a redirect
    // while held only marks it wrong-path. New requests need a free credit.
    always_comb begin
        req_valid_d = 1'b0;
        req_addr_d  = pc_d;
        req_wrong_d = 1'b0;
        if (w_req_hold) begin
            req_valid_d = 1'b1;
            req_addr_d  = req_addr_q;
            req_wrong_d = req_wrong_q || redirect_valid;
        end else begin
            req_valid_d = (state_d == c_st_fetch) && !redirect_valid &&
                          (w_credit_used < c_credit);
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_st_boot;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
            req_wrong_q <= 1'b0;
            out_q       <= '0;
            drop_q      <= '0;
            rsp_pc_q    <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wrong_q <= req_wrong_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            rsp_pc_q    <= rsp_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Buffer entries, one register pair per slot
    generate
        for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_entry
            // Capture a kept response into the slot under the write pointer
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fifo_data_q[i] <= '0;
                    fifo_pc_q[i]   <= '0;
                end else if (w_push && (wr_ptr_q == PW'(i))) begin
                    fifo_data_q[i] <= imem_rsp_data;
                    fifo_pc_q[i]   <= rsp_pc_q;
                end
            end
        end
    endgenerate

    // Remember the head last shown so outputs hold while the buffer is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data_q <= '0;
            last_pc_q   <= '0;
        end else if (instr_valid) begin
            last_data_q <= fifo_data_q[rd_ptr_q];
            last_pc_q   <= fifo_pc_q[rd_ptr_q];
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign instr_valid    = (count_q != '0);
    assign instr_data     = instr_valid ? fifo_data_q[rd_ptr_q] : last_data_q;
    assign instr_pc       = instr_valid ? fifo_pc_q[rd_ptr_q]   : last_pc_q;

`ifndef SYNTHESIS
    // Credit accounting keeps a kept response from landing on a full buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (count_q == c_full)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch with a latency-
//                programmable memory model and an expected-instruction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct {
        int          lat;
        int          mem_pct;
        int          cons_pct;
        int          ncyc;
        int          redir_at;
        logic [31:0] redir_pc;
        int          min_deliv;
    } vec_t;

    mreq_t       mq[$];
    exp_t        eq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          mem_pct = 100;
    int          cons_pct = 100;
    int          delivered = 0;
    logic [31:0] fetch_ptr = RPC;
    logic [31:0] last_pc_taken = '0;
    logic        last_acc = 1'b0;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] acc_log[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int req);
        total++;
        if (act < req) begin
            bad++;
            $display("FAIL %s: got %0d want at least %0d", name, act, req);
        end
    endtask

    // Hold reset for two cycles, clear the models, release on a falling edge
    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        mq.delete();
        eq.delete();
        acc_log.delete();
        fetch_ptr = RPC;
        delivered = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: called and returns on a falling edge
    task automatic step(input bit redir, input logic [31:0] tgt);
        logic  acc;
        logic  take;
        mreq_t m;
        exp_t  e;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memword(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        imem_req_ready = ($urandom_range(99) < mem_pct);
        instr_ready    = ($urandom_range(99) < cons_pct);
        redirect_valid = redir;
        redirect_pc    = tgt;
        acc = imem_req_valid && imem_req_ready;
        last_acc = acc;
        last_acc_addr = imem_req_addr;
        if (acc) begin
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            acc_log.push_back(imem_req_addr);
            if (imem_req_addr == fetch_ptr) begin
                e.pc   = fetch_ptr;
                e.data = memword(fetch_ptr);
                eq.push_back(e);
                fetch_ptr = fetch_ptr + 32'd4;
            end
        end
        take = instr_valid && instr_ready && !redir;
        if (take) begin
            if (eq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_instr: got pc %h, want no instruction", instr_pc);
            end else begin
                e = eq.pop_front();
                check32("instr_pc", instr_pc, e.pc);
                check32("instr_data", instr_data, e.data);
                delivered++;
                last_pc_taken = instr_pc;
            end
        end
        if (redir) begin
            eq.delete();
            fetch_ptr = tgt & ~32'h3;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
    endtask

    initial begin
        vec_t vt[5];
        int   d0;
        int   guard;

        vt[0] = '{lat: 1, mem_pct: 100, cons_pct: 100, ncyc: 60, redir_at: -1, redir_pc: 32'h0, min_deliv: 20};
        vt[1] = '{lat: 3, mem_pct: 100, cons_pct: 100, ncyc: 60, redir_at: -1, redir_pc: 32'h0, min_deliv: 12};
        vt[2] = '{lat: 2, mem_pct: 100, cons_pct: 100, ncyc: 60, redir_at: 20, redir_pc: 32'h0000_1003, min_deliv: 10};
        vt[3] = '{lat: 1, mem_pct: 50, cons_pct: 50, ncyc: 120, redir_at: 40, redir_pc: 32'h0000_4002, min_deliv: 3};
        vt[4] = '{lat: 4, mem_pct: 60, cons_pct: 70, ncyc: 120, redir_at: 30, redir_pc: 32'h8000_0001, min_deliv: 3};

        // Reset state and first fetch; wrap from 0xFFFFFFFC to 0
        do_reset();
        check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("rst_req_addr", imem_req_addr, RPC);
        check32("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check32("rst_instr_data", instr_data, 32'd0);
        check32("rst_instr_pc", instr_pc, 32'd0);
        lat = 1; mem_pct = 100; cons_pct = 100;
        repeat (16) step(1'b0, '0);
        if (acc_log.size() >= 3) begin
            check32("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
            check32("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
            check32("wrap_addr2", acc_log[2], 32'h0000_0000);
        end else begin
            total++; bad++;
            $display("FAIL wrap_addrs: got %0d requests want at least 3", acc_log.size());
        end
        check_ge("t1_delivered", delivered, 6);

        // Consumer stalled: buffer fills to two entries and fetch stops
        do_reset();
        lat = 1; mem_pct = 100; cons_pct = 0;
        repeat (12) step(1'b0, '0);
        check32("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        check32("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("stall_head_pc", instr_pc, RPC);
        check32("stall_head_data", instr_data, memword(RPC));
        check_ge("stall_req_count", 2, acc_log.size());
        cons_pct = 100;
        d0 = delivered;
        repeat (12) step(1'b0, '0);
        check_ge("resume_delivered", delivered - d0, 5);

        // Memory not ready: request and address hold, PC does not advance
        do_reset();
        lat = 1; mem_pct = 0; cons_pct = 100;
        step(1'b0, '0);
        check32("hold_addr0", imem_req_addr, RPC);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0);
            check32("hold_valid", {31'b0, imem_req_valid}, 32'd1);
            check32("hold_addr", imem_req_addr, RPC);
        end
        mem_pct = 100;
        repeat (8) step(1'b0, '0);
        check_ge("hold_release_delivered", delivered, 2);

        // Mid-run reset: outputs return to reset values at once
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check32("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("midrst_req_addr", imem_req_addr, RPC);
        check32("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check32("midrst_instr_data", instr_data, 32'd0);
        check32("midrst_instr_pc", instr_pc, 32'd0);
        @(negedge clk);
        do_reset();
        guard = 0;
        last_acc = 1'b0;
        while (!last_acc && guard < 20) begin
            step(1'b0, '0);
            guard++;
        end
        if (last_acc) check32("midrst_first_addr", last_acc_addr, RPC);
        else begin total++; bad++; $display("FAIL midrst_timeout: got no request want one"); end

        // Redirect with two reads in flight
        do_reset();
        lat = 3; mem_pct = 100; cons_pct = 100;
        guard = 0;
        while (mq.size() < 2 && guard < 30) begin
            step(1'b0, '0);
            guard++;
        end
        check_ge("inflight_two", mq.size(), 2);
        step(1'b1, 32'h0000_0103);
        check32("redir_empty", {31'b0, instr_valid}, 32'd0);
        guard = 0;
        last_acc = 1'b0;
        while (!last_acc && guard < 30) begin
            step(1'b0, '0);
            guard++;
        end
        if (last_acc) check32("redir_req_addr", last_acc_addr, 32'h0000_0100);
        else begin total++; bad++; $display("FAIL redir_req_timeout: got no request want one"); end
        d0 = delivered;
        guard = 0;
        while (delivered == d0 && guard < 30) begin
            step(1'b0, '0);
            guard++;
        end
        check32("redir_first_pc", last_pc_taken, 32'h0000_0100);

        // Redirect coinciding with a response and a consumer pop
        do_reset();
        lat = 1; mem_pct = 100; cons_pct = 100;
        guard = 0;
        while (!(instr_valid && mq.size() > 0 && mq[0].due <= cyc) && guard < 40) begin
            step(1'b0, '0);
            guard++;
        end
        check32("coinc_setup", {31'b0, instr_valid}, 32'd1);
        step(1'b1, 32'h0000_2000);
        check32("coinc_empty", {31'b0, instr_valid}, 32'd0);
        d0 = delivered;
        guard = 0;
        while (delivered == d0 && guard < 30) begin
            step(1'b0, '0);
            guard++;
        end
        check32("coinc_first_pc", last_pc_taken, 32'h0000_2000);

        // Table of traffic patterns checked against the scoreboard
        foreach (vt[k]) begin
            do_reset();
            lat = vt[k].lat;
            mem_pct = vt[k].mem_pct;
            cons_pct = vt[k].cons_pct;
            for (int c = 0; c < vt[k].ncyc; c++) begin
                step(c == vt[k].redir_at, vt[k].redir_pc);
            end
            check_ge($sformatf("vec%0d_delivered", k), delivered, vt[k].min_deliv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
